// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Holds under a global stall, inserts bubbles for flushes and load-use hazards.
module id_ex_pipe_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [11:0]     id_ctrl,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [11:0]     ex_ctrl,
  output logic            load_use_stall
);

  localparam int CTRL_MEMREAD = 1;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic [11:0]     ctrl_q, ctrl_d;
  logic            flush_pending_q, flush_pending_d;

  logic rs1_hit, rs2_hit;

  // A flush remembered across a stall must also suppress the hazard compare.
  assign rs1_hit = id_use_rs1 && (id_rs1 == rd_q);
  assign rs2_hit = id_use_rs2 && (id_rs2 == rd_q);
  assign load_use_stall = valid_q && ctrl_q[CTRL_MEMREAD] && (rd_q != 5'd0) &&
                          (rs1_hit || rs2_hit) && id_valid &&
                          !flush && !flush_pending_q;

  always_comb begin
    valid_d         = valid_q;
    pc_d            = pc_q;
    rs1_data_d      = rs1_data_q;
    rs2_data_d      = rs2_data_q;
    imm_d           = imm_q;
    rs1_d           = rs1_q;
    rs2_d           = rs2_q;
    rd_d            = rd_q;
    ctrl_d          = ctrl_q;
    flush_pending_d = flush_pending_q;

    if (stall) begin
      if (flush) begin
        flush_pending_d = 1'b1;
      end
    end else if (flush || flush_pending_q || load_use_stall) begin
      valid_d         = 1'b0;
      pc_d            = '0;
      rs1_data_d      = '0;
      rs2_data_d      = '0;
      imm_d           = '0;
      rs1_d           = '0;
      rs2_d           = '0;
      rd_d            = '0;
      ctrl_d          = '0;
      flush_pending_d = 1'b0;
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      ctrl_d     = id_valid ? id_ctrl : 12'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q         <= 1'b0;
      pc_q            <= '0;
      rs1_data_q      <= '0;
      rs2_data_q      <= '0;
      imm_q           <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      rd_q            <= '0;
      ctrl_q          <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      pc_q            <= pc_d;
      rs1_data_q      <= rs1_data_d;
      rs2_data_q      <= rs2_data_d;
      imm_q           <= imm_d;
      rs1_q           <= rs1_d;
      rs2_q           <= rs2_d;
      rd_q            <= rd_d;
      ctrl_q          <= ctrl_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_ctrl     = ctrl_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: expected EX contents are queued as each
// ID-stage transaction is driven and compared one edge later.
module tb_id_ex_pipe_reg;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall, flush, id_valid, id_use_rs1, id_use_rs2;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [11:0]     id_ctrl;
  logic            ex_valid, load_use_stall;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [11:0]     ex_ctrl;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .load_use_stall(load_use_stall)
  );

  typedef struct {
    logic            v;
    logic [XLEN-1:0] pc, d1, d2, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [11:0]     ctrl;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic [11:0] ctrl);
    id_valid    = v;
    id_pc       = pc;
    id_rs1_data = {pc[15:0], 16'h1111};
    id_rs2_data = pc ^ 32'hA5A5_0000;
    id_imm      = ~pc;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_ctrl     = ctrl;
  endtask

  function automatic exp_t from_id();
    exp_t e;
    e.v    = id_valid;
    e.pc   = id_pc;
    e.d1   = id_rs1_data;
    e.d2   = id_rs2_data;
    e.imm  = id_imm;
    e.rs1  = id_rs1;
    e.rs2  = id_rs2;
    e.rd   = id_rd;
    e.ctrl = id_valid ? id_ctrl : 12'd0;
    return e;
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e.v = 1'b0; e.pc = '0; e.d1 = '0; e.d2 = '0; e.imm = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.ctrl = '0;
    return e;
  endfunction

  // Push the expected EX contents, clock once, then pop and compare.
  task automatic step(input string tag, input exp_t e);
    exp_t x;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      check({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, x.v});
      check({tag, ".pc"},    ex_pc, x.pc);
      check({tag, ".rs1d"},  ex_rs1_data, x.d1);
      check({tag, ".rs2d"},  ex_rs2_data, x.d2);
      check({tag, ".imm"},   ex_imm, x.imm);
      check({tag, ".rs1"},   {27'd0, ex_rs1}, {27'd0, x.rs1});
      check({tag, ".rs2"},   {27'd0, ex_rs2}, {27'd0, x.rs2});
      check({tag, ".rd"},    {27'd0, ex_rd}, {27'd0, x.rd});
      check({tag, ".ctrl"},  {20'd0, ex_ctrl}, {20'd0, x.ctrl});
      cur = x;
    end
    $display("%0t %s: ex_valid=%0b ex_pc=%h ex_rd=%0d ex_ctrl=%h lus=%0b",
             $time, tag, ex_valid, ex_pc, ex_rd, ex_ctrl, load_use_stall);
  endtask

  task automatic chk_lus(input string tag, input logic exp);
    #1;
    check({tag, ".lus"}, {31'd0, load_use_stall}, {31'd0, exp});
  endtask

  // Assert reset mid-cycle and check the bubble appears immediately.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
    check({tag, ".ctrl"},  {20'd0, ex_ctrl}, 32'd0);
    check({tag, ".rd"},    {27'd0, ex_rd}, 32'd0);
    cur = bubble();
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 12'h000);
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", {31'd0, ex_valid}, 32'd0);
    check("reset.ctrl",  {20'd0, ex_ctrl}, 32'd0);
    check("reset.rd",    {27'd0, ex_rd}, 32'd0);
    check("reset.pc",    ex_pc, 32'd0);
    cur = bubble();
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through
    set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 12'h001);
    chk_lus("pass", 1'b0);
    step("pass", from_id());

    // Load-use: lw x7 then add using x7
    set_id(1'b1, 32'h44, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 12'h00B);
    step("lu_lw", from_id());
    set_id(1'b1, 32'h48, 5'd7, 5'd3, 5'd8, 1'b1, 1'b1, 12'h001);
    chk_lus("lu_hit", 1'b1);
    step("lu_bubble", bubble());
    chk_lus("lu_clear", 1'b0);
    step("lu_add", from_id());

    // x0 never hazards
    set_id(1'b1, 32'h50, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 12'h00B);
    step("x0_lw", from_id());
    set_id(1'b1, 32'h54, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 12'h001);
    chk_lus("x0_nohaz", 1'b0);
    step("x0_add", from_id());

    // Unused rs2 matching a load's rd
    set_id(1'b1, 32'h58, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 12'h00B);
    step("unused_lw", from_id());
    set_id(1'b1, 32'h5C, 5'd3, 5'd7, 5'd10, 1'b1, 1'b0, 12'h011);
    chk_lus("unused_nohaz", 1'b0);
    step("unused_addi", from_id());

    // Invalid ID instruction: no hazard, ctrl gated to zero
    set_id(1'b1, 32'h60, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 12'h00B);
    step("inv_lw", from_id());
    set_id(1'b0, 32'h64, 5'd6, 5'd6, 5'd0, 1'b1, 1'b1, 12'hFFF);
    chk_lus("inv_nohaz", 1'b0);
    step("inv_load", from_id());

    // Flush during a 3-cycle stall
    set_id(1'b1, 32'h68, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, 12'h001);
    step("fs_x", from_id());
    set_id(1'b1, 32'h6C, 5'd4, 5'd5, 5'd12, 1'b1, 1'b1, 12'h301);
    stall = 1'b1;
    flush = 1'b1;
    step("fs_c1", cur);
    flush = 1'b0;
    step("fs_c2", cur);
    step("fs_c3", cur);
    stall = 1'b0;
    step("fs_bubble", bubble());
    step("fs_load", from_id());

    // Hazard seen during a stall, then serviced
    set_id(1'b1, 32'h70, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 12'h00B);
    step("sh_lw", from_id());
    set_id(1'b1, 32'h74, 5'd4, 5'd1, 5'd13, 1'b1, 1'b1, 12'h001);
    stall = 1'b1;
    chk_lus("sh_stall", 1'b1);
    step("sh_hold", cur);
    stall = 1'b0;
    chk_lus("sh_hit", 1'b1);
    step("sh_bubble", bubble());
    chk_lus("sh_clear", 1'b0);
    step("sh_add", from_id());

    // Flush and load-use together
    set_id(1'b1, 32'h78, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 12'h00B);
    step("fl_lw", from_id());
    set_id(1'b1, 32'h7C, 5'd2, 5'd9, 5'd14, 1'b0, 1'b1, 12'h001);
    flush = 1'b1;
    chk_lus("fl_masked", 1'b0);
    step("fl_bubble", bubble());
    flush = 1'b0;
    set_id(1'b1, 32'h80, 5'd2, 5'd3, 5'd15, 1'b1, 1'b1, 12'h001);
    step("fl_next", from_id());

    // Reset while a flush is pending clears it
    stall = 1'b1;
    flush = 1'b1;
    step("rp_pend", cur);
    mid_reset("rp_reset");
    stall = 1'b0;
    flush = 1'b0;
    set_id(1'b1, 32'h84, 5'd5, 5'd6, 5'd16, 1'b1, 1'b1, 12'h081);
    @(negedge clk);
    rst_n = 1'b1;
    step("rp_load", from_id());

    // Asynchronous reset mid-cycle with a valid instruction in EX
    mid_reset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", from_id());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
